// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS main controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: fixed add/sub for address and compare work, funct field
// for R-type execution.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Map the FSM's ALU request (and funct for R-type) to an ALU operation code
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            AOP_ADD: alu_control = ALU_ADD;
            AOP_SUB: alu_control = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_control = ALU_ADD;
                    F_SUB:   alu_control = ALU_SUB;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_SLT:   alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXECUTE/MEM/WB and
// drives every datapath control strobe and select.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int STATE_W    = 4,
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    output logic                  iord,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  pc_en,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            pc_src,
    output logic                  instr_done,
    output logic                  illegal_op,
    output logic [STATE_W-1:0]    state_o
);

    state_t     r_state;
    logic       w_gate;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_done;
    logic       w_illegal;
    logic       w_alu_used;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_dec;

    // State register and next-state sequencing; enable=0 freezes the machine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else if (enable) begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                          r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end else begin
            r_state <= r_state;
        end
    end

    // Moore decode of raw (ungated) controls from the current state
    always_comb begin
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        w_alu_used  = 1'b0;
        w_alu_op    = AOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = 2'b01;
                w_alu_used = 1'b1;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                w_alu_used = 1'b1;
                w_illegal  = ~is_legal_op(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                w_alu_used = 1'b1;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
                w_done      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                w_alu_op   = AOP_FUNCT;
                w_alu_used = 1'b1;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
                w_done      = 1'b1;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                w_alu_op   = AOP_SUB;
                w_alu_used = 1'b1;
                w_branch   = 1'b1;
                pc_src     = 2'b01;
                w_done     = 1'b1;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                pc_src     = 2'b10;
                w_done     = 1'b1;
            end
            default: begin
                iord = 1'b0;
            end
        endcase
    end

    mc_alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct       (funct),
        .alu_control (w_alu_dec)
    );

    // Strobes and pulses are qualified so a frozen or resetting cycle never writes
    assign w_gate      = enable & ~reset;
    assign ir_write    = w_gate & w_ir_write;
    assign mem_write   = w_gate & w_mem_write;
    assign reg_write   = w_gate & w_reg_write;
    assign pc_en       = w_gate & (w_pc_write | (w_branch & zero));
    assign instr_done  = w_gate & w_done;
    assign illegal_op  = w_gate & w_illegal;
    assign alu_control = w_alu_used ? ALU_CTRL_W'(w_alu_dec) : {ALU_CTRL_W{1'b0}};
    assign state_o     = STATE_W'(r_state);

endmodule
